int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt request controller sitting directly upstream of the register file / CP0 block. Synchronises three external interrupt lines, latches them as pending, arbitrates by fixed priority against the CP0 mask and enable, and issues a one-cycle take-interrupt command (break, IE clear, cause code, EPC source) at a safe write-back boundary. Tracks the active handler level so that `eret` restores it, and optionally allows preemption by strictly higher-priority sources.

## Interface
Parameters:
- VEC_BASE, 32'h0000_0400, word address of source-0 handler
- VEC_STRIDE, 32'h0000_0040, word-address distance between handler entries

Ports:
- in_clk  in  1  sole clock, rising edge
- in_RST  in  1  reset, synchronous, active-high
- in_irq  in  3  raw asynchronous interrupt lines; bit 2 highest priority
- in_IE  in  1  global interrupt enable from CP0
- in_INM  in  4  CP0 mask; bit i=1 masks source i (i=0..2); bit 3 masks all
- in_eret  in  1  `eret` retiring in WB this cycle
- in_wb_valid  in  1  WB holds a valid, retiring instruction
- in_wb_pc  in  32  PC of the WB instruction
- out_BK  out  1  take-interrupt pulse to CP0
- out_NIE  out  1  pulse with out_BK: CP0 clears IE
- out_code  out  2  cause code (source index) for CP0
- out_WB_PC  out  32  EPC value for CP0
- out_flush  out  1  flush IF..MEM; equals out_BK
- out_vector  out  32  handler address, valid with out_flush
- out_pending  out  3  pending bits (debug)
- out_level  out  2  active depth (0 = no handler)

## Operation
- Synchroniser: two flops per line, then edge flop; rising edge of synced line sets pending[i].
- Eligible = pending & ~in_INM[2:0], gated by ~in_INM[3] and in_IE.
- Winner = highest eligible index. Take when: winner exists, in_wb_valid=1, in_eret=0, allowed by level rule.
- Level rule: depth 0 -> any winner. Depth>0 -> only with INT_NEST_EN and winner > stack top priority.
- Take cycle (registered outputs, one cycle): out_BK=out_NIE=out_flush=1, out_code=winner, out_WB_PC=in_wb_pc+1, out_vector=VEC_BASE+winner*VEC_STRIDE; pending[winner] cleared; winner pushed; depth+1.
- States: IDLE (depth 0), ISR (depth>=1), TAKE (pulse cycle). IDLE/ISR -> TAKE on take; TAKE -> ISR; ISR -> IDLE on eret with depth 1.
- eret at depth>0: pop, depth-1. eret at depth 0: ignored, no state change.
- Same-source edge in clear cycle: pending stays set (set wins).
- Masked/disabled sources remain pending until unmasked.

## Timing
- Reset: all outputs 0; pending=0, depth=0, synchroniser flops 0, state IDLE.
- Edge-to-pending: 3 cycles after in_irq rises (2 sync + edge).
- Pending-to-out_BK: 1 cycle after take condition true (registered).
- Take suppressed in any eret cycle; earliest take is cycle after eret.
- After TAKE, next take no earlier than 2 cycles later (IE cleared by CP0).
- Reset mid-TAKE or mid-ISR: abandoned, state to reset values next edge.
- Depth saturates at 3; with 3 levels no take.

## Configuration
- INT_CTRL_NEST_EN defined: stack depth 3, preemption by strictly higher priority.
- Undefined: depth max 1; no take while in ISR; stack reduces to one register.

## Structure
- Shared package: cause-code constants (INT_SRC0..2), state encoding (IDLE, TAKE, ISR), VEC_BASE/VEC_STRIDE defaults.
- One sub-module: int_sync_edge (2-flop sync + rising-edge detect, per line, instantiated 3 times).

## Test plan
- Reset then in_irq=3'b001, IE=1, INM=0, wb_valid=1, wb_pc=0x20 -> out_BK pulse 4 cycles later, out_code=0, out_WB_PC=0x21, out_vector=0x400, level=1.
- in_irq=3'b101 simultaneously -> code 2 first, vector 0x480; source 0 stays pending until eret, then taken.
- INM=4'b0010, in_irq=3'b010 -> no out_BK; clear INM -> out_BK with code 1.
- NEST_EN: in ISR of code 0, IE=1, raise irq1 -> out_BK code 1, level=2; eret -> level 1; eret -> level 0.
- eret and eligible pending same cycle -> no out_BK that cycle, out_BK next cycle; eret at level 0 -> no change.
- Assert in_RST during TAKE -> next cycle all outputs 0, pending=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt request controller: cause codes, FSM encoding and
// default handler vector layout.
package int_ctrl_pkg;

  localparam int unsigned NUM_SRC = 3;

  localparam logic [1:0] INT_SRC0 = 2'd0;
  localparam logic [1:0] INT_SRC1 = 2'd1;
  localparam logic [1:0] INT_SRC2 = 2'd2;

  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0400;
  localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0040;

  typedef enum logic [1:0] {
    StIdle,
    StTake,
    StIsr
  } int_state_e;

  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [1:0] src);
    return base + (32'(src) * stride);
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, followed by a rising-edge detector.
module int_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt request controller: sync, pend, fixed-priority arbitration and take-interrupt pulse.
// Define INT_CTRL_NEST_EN for a 3-deep handler stack with preemption by higher priority.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input  logic        in_clk,
  input  logic        in_RST,
  input  logic [2:0]  in_irq,
  input  logic        in_IE,
  input  logic [3:0]  in_INM,
  input  logic        in_eret,
  input  logic        in_wb_valid,
  input  logic [31:0] in_wb_pc,
  output logic        out_BK,
  output logic        out_NIE,
  output logic [1:0]  out_code,
  output logic [31:0] out_WB_PC,
  output logic        out_flush,
  output logic [31:0] out_vector,
  output logic [2:0]  out_pending,
  output logic [1:0]  out_level
);

`ifdef INT_CTRL_NEST_EN
  localparam bit         NestEn   = 1'b1;
  localparam logic [1:0] MaxDepth = 2'd3;
`else
  localparam bit         NestEn   = 1'b0;
  localparam logic [1:0] MaxDepth = 2'd1;
`endif

  logic [2:0]  rise;
  logic [2:0]  pending_q, pending_d, clr;
  logic [1:0]  depth_q, depth_d;
  int_state_e  state_q, state_d;
  logic [2:0]  eligible;
  logic        winner_valid, level_ok, take;
  logic [1:0]  winner, stack_top;
  logic        bk_q;
  logic [1:0]  code_q;
  logic [31:0] epc_q, vector_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    int_sync_edge u_sync (
      .clk_i  (in_clk),
      .rst_i  (in_RST),
      .async_i(in_irq[i]),
      .rise_o (rise[i])
    );
  end

  // Arbitration and level rule
  always_comb begin
    eligible     = pending_q & ~in_INM[2:0] & {3{in_IE & ~in_INM[3]}};
    winner_valid = |eligible;
    winner       = eligible[2] ? INT_SRC2 : (eligible[1] ? INT_SRC1 : INT_SRC0);
    level_ok     = (depth_q == 2'd0) ||
                   (NestEn && (depth_q < MaxDepth) && (winner > stack_top));
    // Blocking in TAKE keeps pulses at least two cycles apart while CP0 clears IE.
    take         = winner_valid && in_wb_valid && !in_eret && level_ok && (state_q != StTake);
  end

  always_comb begin
    clr       = take ? (3'b001 << winner) : 3'b000;
    pending_d = (pending_q & ~clr) | rise;  // a new edge wins over the clear
    depth_d   = depth_q;
    if (take) begin
      depth_d = depth_q + 2'd1;
    end else if (in_eret && (depth_q != 2'd0)) begin
      depth_d = depth_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (take) state_d = StTake;
      StTake: state_d = (depth_d == 2'd0) ? StIdle : StIsr;
      StIsr: begin
        if (take) begin
          state_d = StTake;
        end else if (in_eret && (depth_q == 2'd1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef INT_CTRL_NEST_EN
  logic [1:0] stack_q [3];

  always_comb begin
    stack_top = stack_q[0];
    if (depth_q == 2'd2) begin
      stack_top = stack_q[1];
    end else if (depth_q == 2'd3) begin
      stack_top = stack_q[2];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_RST) begin
      for (int i = 0; i < 3; i++) stack_q[i] <= 2'd0;
    end else if (take) begin
      case (depth_q)
        2'd0:    stack_q[0] <= winner;
        2'd1:    stack_q[1] <= winner;
        default: stack_q[2] <= winner;
      endcase
    end
  end
`else
  logic [1:0] stack_q;

  assign stack_top = stack_q;

  always_ff @(posedge in_clk) begin
    if (in_RST) begin
      stack_q <= 2'd0;
    end else if (take) begin
      stack_q <= winner;
    end
  end
`endif

  always_ff @(posedge in_clk) begin
    if (in_RST) begin
      pending_q <= 3'b000;
      depth_q   <= 2'd0;
      state_q   <= StIdle;
      bk_q      <= 1'b0;
      code_q    <= 2'd0;
      epc_q     <= 32'd0;
      vector_q  <= 32'd0;
    end else begin
      pending_q <= pending_d;
      depth_q   <= depth_d;
      state_q   <= state_d;
      bk_q      <= take;
      code_q    <= take ? winner : 2'd0;
      epc_q     <= take ? (in_wb_pc + 32'd1) : 32'd0;
      vector_q  <= take ? vec_addr(VEC_BASE, VEC_STRIDE, winner) : 32'd0;
    end
  end

  assign out_BK      = bk_q;
  assign out_NIE     = bk_q;
  assign out_flush   = bk_q;
  assign out_code    = code_q;
  assign out_WB_PC   = epc_q;
  assign out_vector  = vector_q;
  assign out_pending = pending_q;
  assign out_level   = depth_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; expectations follow INT_CTRL_NEST_EN when defined.
module tb_int_ctrl;

  logic        in_clk = 1'b0;
  logic        in_RST;
  logic [2:0]  in_irq;
  logic        in_IE;
  logic [3:0]  in_INM;
  logic        in_eret;
  logic        in_wb_valid;
  logic [31:0] in_wb_pc;
  logic        out_BK;
  logic        out_NIE;
  logic [1:0]  out_code;
  logic [31:0] out_WB_PC;
  logic        out_flush;
  logic [31:0] out_vector;
  logic [2:0]  out_pending;
  logic [1:0]  out_level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 in_clk = ~in_clk;

  int_ctrl u_dut (
    .in_clk     (in_clk),
    .in_RST     (in_RST),
    .in_irq     (in_irq),
    .in_IE      (in_IE),
    .in_INM     (in_INM),
    .in_eret    (in_eret),
    .in_wb_valid(in_wb_valid),
    .in_wb_pc   (in_wb_pc),
    .out_BK     (out_BK),
    .out_NIE    (out_NIE),
    .out_code   (out_code),
    .out_WB_PC  (out_WB_PC),
    .out_flush  (out_flush),
    .out_vector (out_vector),
    .out_pending(out_pending),
    .out_level  (out_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic check_take(input string tag, input logic [1:0] code, input logic [31:0] epc,
                            input logic [31:0] vec, input logic [1:0] level);
    check({tag, ".bk"}, 32'(out_BK), 32'd1);
    check({tag, ".nie"}, 32'(out_NIE), 32'd1);
    check({tag, ".flush"}, 32'(out_flush), 32'd1);
    check({tag, ".code"}, 32'(out_code), 32'(code));
    check({tag, ".epc"}, out_WB_PC, epc);
    check({tag, ".vec"}, out_vector, vec);
    check({tag, ".level"}, 32'(out_level), 32'(level));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".bk"}, 32'(out_BK), 32'd0);
    check({tag, ".nie"}, 32'(out_NIE), 32'd0);
    check({tag, ".flush"}, 32'(out_flush), 32'd0);
    check({tag, ".code"}, 32'(out_code), 32'd0);
    check({tag, ".epc"}, out_WB_PC, 32'd0);
    check({tag, ".vec"}, out_vector, 32'd0);
    check({tag, ".pend"}, 32'(out_pending), 32'd0);
    check({tag, ".level"}, 32'(out_level), 32'd0);
  endtask

  initial begin
    in_RST = 1'b1; in_irq = 3'b000; in_IE = 1'b0; in_INM = 4'h0;
    in_eret = 1'b0; in_wb_valid = 1'b0; in_wb_pc = 32'd0;
    step(2);
    check_zero("reset");

    // Single source 0: pending after 3 edges, take on the 4th
    in_RST = 1'b0; in_IE = 1'b1; in_wb_valid = 1'b1; in_wb_pc = 32'h20; in_irq = 3'b001;
    step(3);
    check("t1.pend", 32'(out_pending), 32'h1);
    check("t1.nobk", 32'(out_BK), 32'd0);
    step(1);
    check_take("t1", 2'd0, 32'h21, 32'h400, 2'd1);
    check("t1.clr", 32'(out_pending), 32'h0);
    in_irq = 3'b000;
    step(1);
    check("t1.pulse", 32'(out_BK), 32'd0);
    in_eret = 1'b1;
    step(1);
    check("t1.eret", 32'(out_level), 32'd0);
    in_eret = 1'b0;
    step(3);

    // eret at level 0 is ignored
    in_eret = 1'b1;
    step(1);
    check("e0.level", 32'(out_level), 32'd0);
    check("e0.bk", 32'(out_BK), 32'd0);
    in_eret = 1'b0;

    // Simultaneous 0 and 2: source 2 wins, source 0 waits for eret
    in_wb_pc = 32'h100; in_irq = 3'b101;
    step(3);
    check("t2.pend", 32'(out_pending), 32'h5);
    step(1);
    check_take("t2", 2'd2, 32'h101, 32'h480, 2'd1);
    check("t2.left", 32'(out_pending), 32'h1);
    in_irq = 3'b000;
    step(3);
    check("t2.hold_bk", 32'(out_BK), 32'd0);
    check("t2.hold_pend", 32'(out_pending), 32'h1);
    in_eret = 1'b1;
    step(1);
    check("t2.eret_bk", 32'(out_BK), 32'd0);
    check("t2.eret_lvl", 32'(out_level), 32'd0);
    in_eret = 1'b0;
    step(1);
    check_take("t2b", 2'd0, 32'h101, 32'h400, 2'd1);
    check("t2b.pend", 32'(out_pending), 32'h0);
    in_eret = 1'b1;
    step(1);
    in_eret = 1'b0;
    step(2);

    // Per-source mask holds source 1 pending until cleared
    in_INM = 4'b0010; in_irq = 3'b010;
    step(4);
    check("t3.pend", 32'(out_pending), 32'h2);
    check("t3.masked", 32'(out_BK), 32'd0);
    in_irq = 3'b000;
    step(2);
    check("t3.still", 32'(out_BK), 32'd0);
    in_INM = 4'b0000;
    step(1);
    check_take("t3", 2'd1, 32'h101, 32'h440, 2'd1);
    in_eret = 1'b1;
    step(1);
    in_eret = 1'b0;
    step(2);

    // Global mask bit, then IE low, then release
    in_INM = 4'b1000; in_irq = 3'b100;
    step(5);
    check("t4.gmask", 32'(out_BK), 32'd0);
    check("t4.pend", 32'(out_pending), 32'h4);
    in_INM = 4'b0000; in_IE = 1'b0; in_irq = 3'b000;
    step(2);
    check("t4.ie0", 32'(out_BK), 32'd0);
    in_IE = 1'b1;
    step(1);
    check_take("t4", 2'd2, 32'h101, 32'h480, 2'd1);
    in_eret = 1'b1;
    step(1);
    in_eret = 1'b0;
    step(2);

    // Higher-priority source while in a handler
    in_wb_pc = 32'h200; in_irq = 3'b001;
    step(4);
    check_take("t5a", 2'd0, 32'h201, 32'h400, 2'd1);
    in_irq = 3'b010;
    step(4);
`ifdef INT_CTRL_NEST_EN
    check_take("t5n", 2'd1, 32'h201, 32'h440, 2'd2);
    in_irq = 3'b000;
    step(1);
    check("t5n.pulse", 32'(out_BK), 32'd0);
    in_eret = 1'b1;
    step(1);
    check("t5n.pop1", 32'(out_level), 32'd1);
    step(1);
    check("t5n.pop0", 32'(out_level), 32'd0);
    in_eret = 1'b0;
`else
    check("t5.nonest_bk", 32'(out_BK), 32'd0);
    check("t5.nonest_lvl", 32'(out_level), 32'd1);
    check("t5.nonest_pend", 32'(out_pending), 32'h2);
    in_irq = 3'b000;
    in_eret = 1'b1;
    step(1);
    check("t5.pop", 32'(out_level), 32'd0);
    check("t5.eret_bk", 32'(out_BK), 32'd0);
    in_eret = 1'b0;
    step(1);
    check_take("t5b", 2'd1, 32'h201, 32'h440, 2'd1);
    in_eret = 1'b1;
    step(1);
    check("t5b.pop", 32'(out_level), 32'd0);
    in_eret = 1'b0;
`endif
    step(2);

    // Reset asserted during the take pulse
    in_irq = 3'b101;
    step(4);
    check("t6.bk", 32'(out_BK), 32'd1);
    check("t6.pend", 32'(out_pending), 32'h1);
    in_RST = 1'b1;
    step(1);
    check_zero("t6.rst");
    in_RST = 1'b0; in_irq = 3'b000;
    step(3);
    check("t6.quiet", 32'(out_BK), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
